// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared definitions for the L1 data cache controller: cache geometry,
// address field positions, controller state encoding and a helper that
// builds block-aligned memory addresses.
package cache_ctrl_fsm_pkg;

  localparam int BYTE       = 8;
  localparam int NWAYS      = 4;
  localparam int NSETS      = 128;
  localparam int BLK_BITS   = 512;
  localparam int PA_WIDTH   = 32;
  localparam int WORD_WIDTH = 32;
  localparam int MEM_WIDTH  = 512;
  localparam int IDX_WIDTH  = 7;
  localparam int TAG_WIDTH  = 19;
  localparam int WO_WIDTH   = 4;
  localparam int BO_WIDTH   = 2;

  // Address field ranges: addr = {TAG, INDEX, WOFF, BOFF}
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 13;
  localparam int IDX_MSB  = 12;
  localparam int IDX_LSB  = 6;
  localparam int WOFF_MSB = 5;
  localparam int WOFF_LSB = 2;
  localparam int BOFF_MSB = 1;
  localparam int BOFF_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COMPARE    = 2'd1,
    ST_WRITE_BACK = 2'd2,
    ST_ALLOCATE   = 2'd3
  } state_t;

  function automatic logic [PA_WIDTH-1:0] blk_addr(input logic [TAG_WIDTH-1:0] tag,
                                                   input logic [IDX_WIDTH-1:0] idx);
    return {tag, idx, {(WO_WIDTH + BO_WIDTH){1'b0}}};
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_lru_update.sv
// cache_lru_update: combinational age update for one set.
// Ports:
//   i_ages   - four 2-bit ages, way w at bits [2w+1:2w]
//   i_way    - way being accessed
//   o_ages   - ages after the access (accessed way becomes 0)
//   o_victim - way whose current age is 3 (least recently used)
module cache_lru_update
  import cache_ctrl_fsm_pkg::*;
(
  input  logic [2*NWAYS-1:0] i_ages,
  input  logic [1:0]         i_way,
  output logic [2*NWAYS-1:0] o_ages,
  output logic [1:0]         o_victim
);

  logic [1:0] w_acc_age;

  always_comb begin
    w_acc_age = i_ages[{i_way, 1'b0} +: 2];
    o_ages    = i_ages;
    o_victim  = 2'd0;
    for (int w = 0; w < NWAYS; w++) begin
      // Only ways younger than the accessed one age, so the set stays a permutation of 0..3
      if (2'(w) == i_way)
        o_ages[2*w +: 2] = 2'd0;
      else if (i_ages[2*w +: 2] < w_acc_age)
        o_ages[2*w +: 2] = i_ages[2*w +: 2] + 2'd1;
      if (i_ages[2*w +: 2] == 2'd3)
        o_victim = 2'(w);
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: 4-way set-associative, write-back, write-allocate L1 data
// cache controller with its tag/data/state storage.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   i_addr, i_data_in             - CPU byte address and store data
//   i_rd_en, i_wr_en              - load / store request (store wins)
//   o_busy                        - controller not idle
//   o_done, o_hit                 - completion pulse, original lookup hit
//   o_word_out, o_byte_out        - returned word and addressed byte
//   o_mem_rd_en, o_mem_rd_addr    - block fill request
//   o_mem_wr_en, o_mem_wr_addr    - block write-back request
//   o_mem_data_out, i_mem_data_in - victim block out, fill block in
//   i_mem_ready                   - memory completes current transfer
//
// state       | meaning
// ST_IDLE     | waiting for a request
// ST_COMPARE  | tag lookup; complete on hit, pick victim on miss
// ST_WRITE_BACK | dirty victim block being written to memory
// ST_ALLOCATE | fill block being read from memory into victim way
module cache_ctrl_fsm
  import cache_ctrl_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PA_WIDTH-1:0]   i_addr,
  input  logic [WORD_WIDTH-1:0] i_data_in,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_hit,
  output logic [WORD_WIDTH-1:0] o_word_out,
  output logic [BYTE-1:0]       o_byte_out,
  output logic                  o_mem_rd_en,
  output logic [PA_WIDTH-1:0]   o_mem_rd_addr,
  output logic                  o_mem_wr_en,
  output logic [PA_WIDTH-1:0]   o_mem_wr_addr,
  output logic [MEM_WIDTH-1:0]  o_mem_data_out,
  input  logic [MEM_WIDTH-1:0]  i_mem_data_in,
  input  logic                  i_mem_ready
);

  logic [TAG_WIDTH-1:0]  r_tag_arr  [NWAYS][NSETS];
  logic [BLK_BITS-1:0]   r_data_arr [NWAYS][NSETS];
  logic [NSETS-1:0]      r_valid    [NWAYS];
  logic [NSETS-1:0]      r_dirty    [NWAYS];
  logic [2*NWAYS-1:0]    r_lru      [NSETS];

  state_t                r_state;
  logic [PA_WIDTH-1:0]   r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic                  r_is_store;
  logic                  r_first;
  logic [1:0]            r_victim;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic [WO_WIDTH-1:0]   w_woff;
  logic [BO_WIDTH-1:0]   w_boff;
  logic                  w_hit;
  logic [1:0]            w_hit_way;
  logic [1:0]            w_victim;
  logic [1:0]            w_lru_victim;
  logic                  w_found_inv;
  logic [2*NWAYS-1:0]    w_lru_new;
  logic [BLK_BITS-1:0]   w_hit_blk;
  logic [WORD_WIDTH-1:0] w_new_word;

  assign w_tag  = r_addr[TAG_MSB:TAG_LSB];
  assign w_idx  = r_addr[IDX_MSB:IDX_LSB];
  assign w_woff = r_addr[WOFF_MSB:WOFF_LSB];
  assign w_boff = r_addr[BOFF_MSB:BOFF_LSB];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 2'd0;
    for (int w = 0; w < NWAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag_arr[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 2'(w);
      end
    end
  end

  cache_lru_update u_lru (
    .i_ages   (r_lru[w_idx]),
    .i_way    (w_hit_way),
    .o_ages   (w_lru_new),
    .o_victim (w_lru_victim)
  );

  // Invalid ways are filled first, lowest index; LRU only once the set is full
  always_comb begin
    w_victim    = w_lru_victim;
    w_found_inv = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!r_valid[w][w_idx] && !w_found_inv) begin
        w_victim    = 2'(w);
        w_found_inv = 1'b1;
      end
    end
  end

  assign w_hit_blk  = r_data_arr[w_hit_way][w_idx];
  assign w_new_word = r_is_store ? r_wdata : w_hit_blk[{w_woff, 5'b0} +: WORD_WIDTH];

  // Tag/data arrays carry no reset; an async reset forces ST_IDLE so no
  // in-flight fill or store can land here.
  always_ff @(posedge clk) begin
    if (r_state == ST_ALLOCATE && i_mem_ready) begin
      r_data_arr[r_victim][w_idx] <= i_mem_data_in;
      r_tag_arr[r_victim][w_idx]  <= w_tag;
    end else if (r_state == ST_COMPARE && w_hit && r_is_store) begin
      r_data_arr[w_hit_way][w_idx][{w_woff, 5'b0} +: WORD_WIDTH] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_is_store     <= 1'b0;
      r_first        <= 1'b0;
      r_victim       <= 2'd0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_hit          <= 1'b0;
      o_word_out     <= '0;
      o_byte_out     <= '0;
      o_mem_rd_en    <= 1'b0;
      o_mem_rd_addr  <= '0;
      o_mem_wr_en    <= 1'b0;
      o_mem_wr_addr  <= '0;
      o_mem_data_out <= '0;
      for (int w = 0; w < NWAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < NSETS; s++)
        r_lru[s] <= {2'd3, 2'd2, 2'd1, 2'd0};
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rd_en || i_wr_en) begin
            r_addr     <= i_addr;
            r_wdata    <= i_data_in;
            r_is_store <= i_wr_en;
            r_first    <= 1'b1;
            o_busy     <= 1'b1;
            r_state    <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (w_hit) begin
            o_done       <= 1'b1;
            o_hit        <= r_first;
            o_word_out   <= w_new_word;
            o_byte_out   <= w_new_word[{w_boff, 3'b0} +: BYTE];
            r_lru[w_idx] <= w_lru_new;
            if (r_is_store)
              r_dirty[w_hit_way][w_idx] <= 1'b1;
            o_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_first  <= 1'b0;
            r_victim <= w_victim;
            if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
              o_mem_wr_en    <= 1'b1;
              o_mem_wr_addr  <= blk_addr(r_tag_arr[w_victim][w_idx], w_idx);
              o_mem_data_out <= r_data_arr[w_victim][w_idx];
              r_state        <= ST_WRITE_BACK;
            end else begin
              o_mem_rd_en   <= 1'b1;
              o_mem_rd_addr <= blk_addr(w_tag, w_idx);
              r_state       <= ST_ALLOCATE;
            end
          end
        end
        ST_WRITE_BACK: begin
          if (i_mem_ready) begin
            o_mem_wr_en   <= 1'b0;
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= blk_addr(w_tag, w_idx);
            r_state       <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          if (i_mem_ready) begin
            o_mem_rd_en               <= 1'b0;
            r_valid[r_victim][w_idx]  <= 1'b1;
            r_dirty[r_victim][w_idx]  <= 1'b0;
            r_state                   <= ST_COMPARE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Testbench for cache_ctrl_fsm: table-driven directed vectors, hand-written
// multi-cycle sequences and randomized traffic against a recency-ordered
// reference cache model with its own memory image.
module tb_cache_ctrl_fsm;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [31:0]  i_data_in = '0;
  logic         i_rd_en = 1'b0;
  logic         i_wr_en = 1'b0;
  logic         o_busy, o_done, o_hit;
  logic [31:0]  o_word_out;
  logic [7:0]   o_byte_out;
  logic         o_mem_rd_en, o_mem_wr_en;
  logic [31:0]  o_mem_rd_addr, o_mem_wr_addr;
  logic [511:0] o_mem_data_out;
  logic [511:0] i_mem_data_in = '0;
  logic         i_mem_ready = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  cache_ctrl_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_addr         (i_addr),
    .i_data_in      (i_data_in),
    .i_rd_en        (i_rd_en),
    .i_wr_en        (i_wr_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_hit          (o_hit),
    .o_word_out     (o_word_out),
    .o_byte_out     (o_byte_out),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_rd_addr  (o_mem_rd_addr),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_wr_addr  (o_mem_wr_addr),
    .o_mem_data_out (o_mem_data_out),
    .i_mem_data_in  (i_mem_data_in),
    .i_mem_ready    (i_mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  function automatic logic [511:0] init_blk(input logic [31:0] ba);
    logic [511:0] b;
    for (int k = 0; k < 16; k++)
      b[k*32 +: 32] = 32'h1000_0000 + 32'(k) + ((ba - 32'h40) << 4);
    return b;
  endfunction

  // ---------------- memory responder ----------------
  logic [511:0] phys_mem [logic [31:0]];
  int           mem_lat = 0;
  int           wait_cnt = 0;
  int           n_rd = 0, n_wb = 0;
  logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;
  logic [511:0] last_wb_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      i_mem_ready = 1'b0;
      wait_cnt    = 0;
    end else if (i_mem_ready) begin
      i_mem_ready = 1'b0;
      wait_cnt    = 0;
    end else if (o_mem_wr_en || o_mem_rd_en) begin
      if (wait_cnt >= mem_lat) begin
        i_mem_ready = 1'b1;
        if (o_mem_wr_en) begin
          n_wb++;
          last_wb_addr = o_mem_wr_addr;
          last_wb_data = o_mem_data_out;
          phys_mem[o_mem_wr_addr] = o_mem_data_out;
        end else begin
          n_rd++;
          last_rd_addr  = o_mem_rd_addr;
          i_mem_data_in = phys_mem.exists(o_mem_rd_addr) ? phys_mem[o_mem_rd_addr]
                                                         : init_blk(o_mem_rd_addr);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  // Each set holds up to four lines; replacement picks an empty line, else the
  // line with the oldest access time stamp.
  typedef struct {
    bit           v;
    bit           dty;
    logic [18:0]  tag;
    logic [511:0] data;
    int unsigned  t;
  } line_t;

  line_t        ml [128][4];
  logic [511:0] ref_mem [logic [31:0]];
  int unsigned  now_t = 0;

  task automatic model_reset();
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 4; w++) begin
        ml[s][w].v   = 1'b0;
        ml[s][w].dty = 1'b0;
        ml[s][w].t   = 0;
      end
  endtask

  task automatic model_access(input logic [31:0] a, input bit st, input logic [31:0] d,
                              output logic eh, output logic [31:0] ew, output logic ewb,
                              output logic [31:0] ewa, output logic [511:0] ewd);
    int s, w, wo;
    logic [18:0] tg;
    logic [31:0] ba;
    line_t ln;
    s  = int'(a[12:6]);
    tg = a[31:13];
    wo = int'(a[5:2]);
    now_t++;
    w = -1;
    ewb = 1'b0; ewa = '0; ewd = '0;
    for (int i = 0; i < 4; i++)
      if (ml[s][i].v && ml[s][i].tag == tg) w = i;
    eh = (w >= 0);
    if (w < 0) begin
      for (int i = 0; i < 4; i++)
        if (!ml[s][i].v && w < 0) w = i;
      if (w < 0) begin
        w = 0;
        for (int i = 1; i < 4; i++)
          if (ml[s][i].t < ml[s][w].t) w = i;
      end
      ln = ml[s][w];
      if (ln.v && ln.dty) begin
        ewb = 1'b1;
        ewa = {ln.tag, a[12:6], 6'b0};
        ewd = ln.data;
        ref_mem[ewa] = ln.data;
      end
      ba     = {tg, a[12:6], 6'b0};
      ln.v   = 1'b1;
      ln.dty = 1'b0;
      ln.tag = tg;
      ln.data = ref_mem.exists(ba) ? ref_mem[ba] : init_blk(ba);
    end else begin
      ln = ml[s][w];
    end
    if (st) begin
      ln.data[wo*32 +: 32] = d;
      ln.dty = 1'b1;
    end
    ew   = ln.data[wo*32 +: 32];
    ln.t = now_t;
    ml[s][w] = ln;
  endtask

  // ---------------- request driver ----------------
  int lat = 0;

  task automatic do_req(input logic [31:0] a, input bit st, input logic [31:0] d);
    logic eh, ewb;
    logic [31:0] ew, ewa;
    logic [511:0] ewd;
    logic [7:0] eb;
    int cyc;
    n_wb = 0;
    n_rd = 0;
    model_access(a, st, d, eh, ew, ewb, ewa, ewd);
    eb = ew[a[1:0]*8 +: 8];
    @(negedge clk);
    i_addr = a; i_data_in = d; i_wr_en = st; i_rd_en = !st;
    @(negedge clk);
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    cyc = 1;
    while (!o_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    if (!o_done) begin
      timeout("req_done");
      return;
    end
    check("req_hit", o_hit, eh);
    check("req_word", o_word_out, ew);
    check("req_byte", o_byte_out, eb);
    check("req_wb_cnt", n_wb, ewb);
    if (ewb) begin
      check("req_wb_addr", last_wb_addr, ewa);
      check("req_wb_data", last_wb_data, ewd);
    end
    @(negedge clk);
    check("done_pulse", o_done, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          st;
    logic [31:0] data;
    logic        exp_hit;
    logic [31:0] exp_word;
    logic [7:0]  exp_byte;
    int          exp_lat;
    int          exp_rd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eh, ewb;
    logic [31:0] ew, ewa, a;
    logic [511:0] ewd;
    int cyc;
    logic [6:0] idx_pool [3];

    tbl[0] = '{32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h1000_0000, 8'h00, 4, 1};
    tbl[1] = '{32'h0000_0044, 1'b0, 32'h0,         1'b1, 32'h1000_0001, 8'h01, 2, 0};
    tbl[2] = '{32'h0000_0047, 1'b0, 32'h0,         1'b1, 32'h1000_0001, 8'h10, 2, 0};
    tbl[3] = '{32'h0000_0048, 1'b1, 32'hDEADBEEF,  1'b1, 32'hDEADBEEF,  8'hEF, 2, 0};
    tbl[4] = '{32'h0000_0048, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  8'hEF, 2, 0};
    tbl[5] = '{32'h0000_004A, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  8'hAD, 2, 0};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {o_busy, o_done, o_hit, o_mem_rd_en, o_mem_wr_en}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_word", o_word_out, 32'h0);
    check("rst_byte", o_byte_out, 8'h0);
    check("rst_mem_addr", {o_mem_rd_addr, o_mem_wr_addr}, 64'h0);
    check("rst_mem_data", o_mem_data_out, 512'h0);

    // Directed table: fill, hits, byte select, store hit
    mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].addr, tbl[i].st, tbl[i].data);
      check("tbl_hit", o_hit, tbl[i].exp_hit);
      check("tbl_word", o_word_out, tbl[i].exp_word);
      check("tbl_byte", o_byte_out, tbl[i].exp_byte);
      check("tbl_lat", lat, tbl[i].exp_lat);
      check("tbl_rd", n_rd, tbl[i].exp_rd);
      check("tbl_wb", n_wb, 0);
    end
    check("tbl_rd_addr", last_rd_addr, 32'h40);

    // Fill set 1, then a dirty eviction of block 0x40
    do_req(32'h2040, 1'b0, 32'h0);
    do_req(32'h4040, 1'b0, 32'h0);
    do_req(32'h6040, 1'b0, 32'h0);
    do_req(32'h8040, 1'b0, 32'h0);
    check("evict_hit", o_hit, 1'b0);
    check("evict_wb_cnt", n_wb, 1);
    check("evict_wb_addr", last_wb_addr, 32'h40);
    check("evict_wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
    check("evict_rd_addr", last_rd_addr, 32'h8040);

    // LRU order in set 5: A B C D, re-read A, E evicts B
    do_req(32'h0140, 1'b0, 32'h0);
    do_req(32'h2140, 1'b0, 32'h0);
    do_req(32'h4140, 1'b0, 32'h0);
    do_req(32'h6140, 1'b0, 32'h0);
    do_req(32'h0140, 1'b0, 32'h0);
    check("lru_a_rehit", o_hit, 1'b1);
    do_req(32'h8140, 1'b0, 32'h0);
    check("lru_e_miss", o_hit, 1'b0);
    do_req(32'h2140, 1'b0, 32'h0);
    check("lru_b_miss", o_hit, 1'b0);
    do_req(32'h0140, 1'b0, 32'h0);
    check("lru_a_hit", o_hit, 1'b1);

    // Memory stall: read request held stable, extra request ignored
    mem_lat = 5;
    n_rd = 0;
    model_access(32'h0001_0000, 1'b0, 32'h0, eh, ew, ewb, ewa, ewd);
    @(negedge clk);
    i_addr = 32'h0001_0000; i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    cyc = 0;
    while (!o_mem_rd_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_mem_rd_en) timeout("stall_rd_en");
    for (int k = 0; k < 5; k++) begin
      check("stall_rd_en", o_mem_rd_en, 1'b1);
      check("stall_rd_addr", o_mem_rd_addr, 32'h0001_0000);
      check("stall_busy", o_busy, 1'b1);
      check("stall_ready", i_mem_ready, 1'b0);
      if (k == 1) begin
        i_addr = 32'h40; i_rd_en = 1'b1;
      end else begin
        i_rd_en = 1'b0;
      end
      @(negedge clk);
    end
    i_rd_en = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_done) timeout("stall_done");
    check("stall_hit", o_hit, 1'b0);
    check("stall_word", o_word_out, ew);
    @(negedge clk);
    @(negedge clk);
    check("stall_idle", o_busy, 1'b0);
    check("stall_rd_cnt", n_rd, 1);

    // Reset during ALLOCATE aborts the fill
    @(negedge clk);
    i_addr = 32'h0002_0000; i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    cyc = 0;
    while (!o_mem_rd_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_mem_rd_en) timeout("abort_rd_en");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {o_busy, o_done, o_hit, o_mem_rd_en, o_mem_wr_en}, 5'b0);
    check("abort_word", {o_word_out, o_byte_out}, 40'h0);
    check("abort_rd_addr", o_mem_rd_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mem_lat = 0;
    do_req(32'h0002_0000, 1'b0, 32'h0);
    check("abort_rereq_miss", o_hit, 1'b0);
    check("abort_rereq_rd", n_rd, 1);

    // Randomized traffic against the reference model
    idx_pool[0] = 7'd1; idx_pool[1] = 7'd5; idx_pool[2] = 7'd9;
    for (int n = 0; n < 300; n++) begin
      mem_lat = $urandom_range(0, 3);
      a = {19'($urandom_range(0, 7)), idx_pool[$urandom_range(0, 2)],
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      do_req(a, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
